// File: rtl/duck_pkg.sv
// Shared types and constants for the Duck Hunt game-flow logic: FSM state
// encoding, screen size, start-button geometry and a no-wrap span test.
package duck_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    FALL  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int START_X0_DEF = 245;
  localparam int START_Y0_DEF = 320;
  localparam int START_W_DEF  = 150;
  localparam int START_H_DEF  = 50;

  // True when p lies in [lo, lo+len); the 11-bit sum keeps a box near the
  // right/bottom edge of the 10-bit space from wrapping around to zero.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo,
                                   input logic [10:0] len);
    logic [10:0] hi;
    hi = {1'b0, lo} + len;
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/click_edge_sync.sv
// Two-flop synchronizer for an asynchronous button, followed by a registered
// rising-edge detector. The pulse is one clock wide, three clocks after the rise.
module click_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = btn_raw;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/shot_game_ctrl.sv
// Duck Hunt game-flow FSM: turns left-button clicks plus cursor/duck geometry
// into game state, bullet and hit counters, the kill animation and the score.
module shot_game_ctrl
  import duck_pkg::*;
#(
  parameter int NUM_BULLETS = 16,
  parameter int KILL_FRAMES = 60,
  parameter int START_X0    = START_X0_DEF,
  parameter int START_Y0    = START_Y0_DEF,
  parameter int START_W     = START_W_DEF,
  parameter int START_H     = START_H_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] mouse_button,
  input  logic [9:0] cursor_x,
  input  logic [9:0] cursor_y,
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] box_s,
  output logic       start,
  output logic       endgame,
  output logic       kill,
  output logic [7:0] click_count,
  output logic [7:0] bullets_left,
  output logic [7:0] hit_count,
  output logic [7:0] score,
  output logic [1:0] state_dbg
);

  if (KILL_FRAMES < 1) begin : g_bad_kill_frames
    $error("shot_game_ctrl: KILL_FRAMES must be at least 1");
  end

  localparam logic [7:0]  NB     = 8'(NUM_BULLETS);
  localparam logic [15:0] KF     = 16'(KILL_FRAMES);
  localparam logic [9:0]  BTN_X0 = 10'(START_X0);
  localparam logic [9:0]  BTN_Y0 = 10'(START_Y0);
  localparam logic [10:0] BTN_W  = 11'(START_W);
  localparam logic [10:0] BTN_H  = 11'(START_H);

  logic shot;
  logic unused_btn;
  logic hit, on_button;

  game_state_t state_q, state_d;
  logic [7:0]  click_q, click_d;
  logic [7:0]  bullets_q, bullets_d;
  logic [7:0]  hit_q, hit_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] timer_q, timer_d;
  logic        kill_q, kill_d;
  logic        start_q, start_d;
  logic        endgame_q, endgame_d;

  assign unused_btn = ^mouse_button[7:1];

  click_edge_sync u_left_click (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_raw (mouse_button[0]),
    .pulse   (shot)
  );

  assign hit       = in_span(cursor_x, box_x, {1'b0, box_s}) &&
                     in_span(cursor_y, box_y, {1'b0, box_s});
  assign on_button = in_span(cursor_x, BTN_X0, BTN_W) &&
                     in_span(cursor_y, BTN_Y0, BTN_H);

  always_comb begin
    state_d   = state_q;
    click_d   = click_q;
    hit_d     = hit_q;
    score_d   = score_q;
    timer_d   = timer_q;
    kill_d    = kill_q;
    start_d   = start_q;
    endgame_d = endgame_q;

    unique case (state_q)
      TITLE: begin
        if (shot && on_button) begin
          state_d = PLAY;
          click_d = 8'd0;
          hit_d   = 8'd0;
          start_d = 1'b1;
        end
      end

      PLAY: begin
        if (shot && (click_q < NB)) begin
          click_d = click_q + 8'd1;
          if (hit) begin
            hit_d   = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
            kill_d  = 1'b1;
            timer_d = KF;
            state_d = FALL;
          end else if (click_q + 8'd1 == NB) begin
            state_d   = OVER;
            score_d   = hit_q;
            start_d   = 1'b0;
            endgame_d = 1'b1;
          end
        end
      end

      // Clicks are ignored here; only the frame timer advances the state.
      FALL: begin
        if (frame_tick && (timer_q != 16'd0)) begin
          timer_d = timer_q - 16'd1;
          if (timer_q == 16'd1) begin
            kill_d = 1'b0;
            if (click_q == NB) begin
              state_d   = OVER;
              score_d   = hit_q;
              start_d   = 1'b0;
              endgame_d = 1'b1;
            end else begin
              state_d = PLAY;
            end
          end
        end
      end

      OVER: begin
        if (shot) begin
          state_d   = TITLE;
          endgame_d = 1'b0;
        end
      end

      default: state_d = TITLE;
    endcase

    bullets_d = NB - click_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= TITLE;
      click_q   <= 8'd0;
      bullets_q <= NB;
      hit_q     <= 8'd0;
      score_q   <= 8'd0;
      timer_q   <= 16'd0;
      kill_q    <= 1'b0;
      start_q   <= 1'b0;
      endgame_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      click_q   <= click_d;
      bullets_q <= bullets_d;
      hit_q     <= hit_d;
      score_q   <= score_d;
      timer_q   <= timer_d;
      kill_q    <= kill_d;
      start_q   <= start_d;
      endgame_q <= endgame_d;
    end
  end

  assign start        = start_q;
  assign endgame      = endgame_q;
  assign kill         = kill_q;
  assign click_count  = click_q;
  assign bullets_left = bullets_q;
  assign hit_count    = hit_q;
  assign score        = score_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_shot_game_ctrl.sv
// Scoreboard bench for shot_game_ctrl: directed click/tick scenarios push the
// expected output snapshot; a negedge monitor pops and compares it.
`timescale 1ns/1ps
module tb_shot_game_ctrl;

  localparam logic [1:0] S_TITLE = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_FALL  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] mouse_button;
  logic [9:0] cursor_x, cursor_y;
  logic [9:0] box_x, box_y, box_s;
  logic       start, endgame, kill;
  logic [7:0] click_count, bullets_left, hit_count, score;
  logic [1:0] state_dbg;

  typedef struct packed {
    logic [1:0] st;
    logic       start;
    logic       endg;
    logic       kill;
    logic [7:0] click;
    logic [7:0] bullets;
    logic [7:0] hits;
    logic [7:0] score;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  shot_game_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .mouse_button (mouse_button),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .box_x        (box_x),
    .box_y        (box_y),
    .box_s        (box_s),
    .start        (start),
    .endgame      (endgame),
    .kill         (kill),
    .click_count  (click_count),
    .bullets_left (bullets_left),
    .hit_count    (hit_count),
    .score        (score),
    .state_dbg    (state_dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: compares each pushed expectation against the live outputs.
  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "state", int'(state_dbg), int'(e.st));
      cmp(nm, "start", int'(start), int'(e.start));
      cmp(nm, "endgame", int'(endgame), int'(e.endg));
      cmp(nm, "kill", int'(kill), int'(e.kill));
      cmp(nm, "click_count", int'(click_count), int'(e.click));
      cmp(nm, "bullets_left", int'(bullets_left), int'(e.bullets));
      cmp(nm, "hit_count", int'(hit_count), int'(e.hits));
      cmp(nm, "score", int'(score), int'(e.score));
      $display("txn %-18s state=%0d start=%0d end=%0d kill=%0d clicks=%0d bullets=%0d hits=%0d score=%0d",
               nm, state_dbg, start, endgame, kill, click_count, bullets_left, hit_count, score);
    end
  end

  task automatic expect_out(input string nm, input logic [1:0] st, input logic st_on,
                            input logic en, input logic kl, input int clk_n,
                            input int bul, input int hits, input int sc);
    exp_t e;
    e.st = st; e.start = st_on; e.endg = en; e.kill = kl;
    e.click = 8'(clk_n); e.bullets = 8'(bul); e.hits = 8'(hits); e.score = 8'(sc);
    exp_q.push_back(e);
    name_q.push_back(nm);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge Clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard got %0d pending expected 0 pending", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic click_at(input int x, input int y, input int hold);
    @(negedge Clk);
    cursor_x     = 10'(x);
    cursor_y     = 10'(y);
    mouse_button = 8'h01;
    repeat (hold) @(negedge Clk);
    mouse_button = 8'h06;
    repeat (4) @(negedge Clk);
  endtask

  task automatic shoot(input int x, input int y);
    click_at(x, y, 6);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    frame_tick   = 1'b0;
    mouse_button = 8'h00;
    cursor_x     = 10'd0;
    cursor_y     = 10'd0;
    box_x        = 10'd100;
    box_y        = 10'd100;
    box_s        = 10'd64;
    repeat (3) @(negedge Clk);
    expect_out("reset", S_TITLE, 0, 0, 0, 0, 16, 0, 0);
    Reset = 1'b0;

    shoot(10, 10);
    expect_out("title_ignore", S_TITLE, 0, 0, 0, 0, 16, 0, 0);
    shoot(300, 340);
    expect_out("start", S_PLAY, 1, 0, 0, 0, 16, 0, 0);
    shoot(164, 163);
    expect_out("miss_edge", S_PLAY, 1, 0, 0, 1, 15, 0, 0);
    shoot(100, 100);
    expect_out("hit_corner", S_FALL, 1, 0, 1, 2, 14, 1, 0);
    shoot(500, 50);
    expect_out("fall_shot", S_FALL, 1, 0, 1, 2, 14, 1, 0);
    ticks(59);
    expect_out("fall_59", S_FALL, 1, 0, 1, 2, 14, 1, 0);
    ticks(1);
    expect_out("fall_exit", S_PLAY, 1, 0, 0, 2, 14, 1, 0);
    click_at(500, 50, 1000);
    expect_out("held_button", S_PLAY, 1, 0, 0, 3, 13, 1, 0);
    for (int i = 0; i < 12; i++) shoot(500, 50);
    expect_out("miss15", S_PLAY, 1, 0, 0, 15, 1, 1, 0);
    shoot(500, 50);
    expect_out("over_score1", S_OVER, 0, 1, 0, 16, 0, 1, 1);
    shoot(10, 10);
    expect_out("over_to_title", S_TITLE, 0, 0, 0, 16, 0, 1, 1);

    shoot(300, 340);
    expect_out("restart", S_PLAY, 1, 0, 0, 0, 16, 0, 1);
    for (int i = 0; i < 16; i++) shoot(500, 50);
    expect_out("over_all_miss", S_OVER, 0, 1, 0, 16, 0, 0, 0);
    shoot(500, 50);
    expect_out("shot17", S_TITLE, 0, 0, 0, 16, 0, 0, 0);

    shoot(300, 340);
    expect_out("restart2", S_PLAY, 1, 0, 0, 0, 16, 0, 0);
    for (int i = 0; i < 15; i++) shoot(500, 50);
    expect_out("miss15b", S_PLAY, 1, 0, 0, 15, 1, 0, 0);
    shoot(130, 120);
    expect_out("last_hit", S_FALL, 1, 0, 1, 16, 0, 1, 0);
    ticks(60);
    expect_out("last_fall_over", S_OVER, 0, 1, 0, 16, 0, 1, 1);
    shoot(500, 50);
    expect_out("title3", S_TITLE, 0, 0, 0, 16, 0, 1, 1);

    shoot(300, 340);
    expect_out("restart3", S_PLAY, 1, 0, 0, 0, 16, 0, 1);
    box_x = 10'd1000;
    box_y = 10'd1000;
    box_s = 10'd40;
    shoot(1020, 1010);
    expect_out("wrap_hit", S_FALL, 1, 0, 1, 1, 15, 1, 1);

    @(posedge Clk);
    #1 Reset = 1'b1;
    expect_out("async_reset", S_TITLE, 0, 0, 0, 0, 16, 0, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    shoot(10, 10);
    expect_out("title_after_reset", S_TITLE, 0, 0, 0, 0, 16, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
